mips32_mem_arbiter: RTL and testbench
=====================================

# mips32_mem_arbiter

Single-port memory arbiter for the MIPS32 pipeline. It shares one unified instruction/data memory between the IF-stage instruction fetch and the MEM-stage load/store. Each cycle it grants at most one requester and drives the memory port, then routes the read data back one cycle later. Data accesses have priority; a starvation guard protects fetch, and fetch is suppressed while the core is halted.

## Interface
- ADDR_W, 10, word address width
- DATA_W, 32, data width
- STARVE_LIMIT, 4, consecutive denied fetch cycles before fetch wins priority (1..15)
- clk1  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- halted  in  1  core HALTED flag; while 1, if_req is ignored
- if_req  in  1  fetch request
- if_addr  in  ADDR_W  fetch word address
- if_gnt  out  1  fetch granted this cycle (combinational)
- if_rvalid  out  1  fetch read data valid (registered)
- if_rdata  out  DATA_W  fetch read data
- dm_req  in  1  data request
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data word address
- dm_wdata  in  DATA_W  store data
- dm_gnt  out  1  data granted this cycle (combinational)
- dm_rvalid  out  1  load data valid (registered)
- dm_rdata  out  DATA_W  load data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after a read strobe
- conflict_cnt  out  16  saturating count of cycles with both requests live

## Operation
- Effective fetch request: ifr = if_req & ~halted.
- Priority: dm_req wins over ifr, except when starve_cnt == STARVE_LIMIT. In that case ifr wins.
- Exactly one of if_gnt/dm_gnt is 1 when any request is live; both are 0 otherwise.
- Granted request drives the memory port in the same cycle:
  - mem_en=1
  - mem_we = dm_we for a data grant, 0 for a fetch grant
  - mem_addr and mem_wdata taken from the winner
  - mem_wdata is 0 for a fetch grant
- When idle: mem_en=0, mem_we=0, and mem_addr/mem_wdata hold 0.
- starve_cnt (4-bit internal):
  - Cleared on if_gnt or when ifr=0.
  - Otherwise increments when ifr & ~if_gnt, saturating at STARVE_LIMIT.
- Response tracking: register rsp_owner ∈ {NONE, IF, DM}.
  - Set to IF on a fetch grant.
  - Set to DM on a load grant.
  - Set to NONE on a store grant or when idle.
- Next cycle: if_rvalid = (rsp_owner==IF) and dm_rvalid = (rsp_owner==DM). The matching *_rdata = mem_rdata; the other *_rdata is 0.
- Stores never produce rvalid.
- conflict_cnt increments each cycle with dm_req & ifr, saturating at 16'hFFFF.
- A requester that is not granted keeps its request and inputs stable; the arbiter holds no queue.

## Timing
- Grant latency: 0 cycles (combinational from req/halted/starve_cnt).
- Read latency: rvalid exactly 1 cycle after the grant cycle. Back-to-back grants give rvalid every cycle.
- Reset (rst_n=0, asynchronous):
  - starve_cnt=0, rsp_owner=NONE, conflict_cnt=0.
  - if_rvalid=dm_rvalid=0, if_rdata=dm_rdata=0.
  - Grants and mem_en are forced to 0 while rst_n=0.
- Reset during an outstanding read: the response is dropped and no rvalid follows after release.
- First grant is possible in the first cycle with rst_n=1.
- halted rising while fetch is starved: starve_cnt clears the next edge, and dm proceeds unblocked.
- halted asserted in the same cycle as a fetch grant would occur: no fetch grant.
- An rvalid already pending from the previous cycle still completes.
- Starvation-boost cycle with both requesting: fetch granted, dm_gnt=0, and conflict_cnt still increments.

## Test plan
- Reset: hold rst_n=0 with both reqs high -> all grants, mem_en, rvalids 0 and conflict_cnt=0. Release -> dm_gnt=1 on the first cycle.
- Fetch only: if_req with if_addr=0..7 over consecutive cycles, memory preloaded Mem[k]=k+100 -> if_gnt every cycle and if_rvalid 1 cycle later with if_rdata=100..107.
- Data priority plus starvation, STARVE_LIMIT=4: dm_req and if_req held high for 10 cycles -> dm_gnt cycles 0-3, if_gnt cycle 4, dm cycles 5-8, if_gnt cycle 9. conflict_cnt=10.
- Load/store: dm store addr 120 data 85, then load 120 -> mem_we=1 with no rvalid on the store. Load returns dm_rvalid=1 with dm_rdata=85 one cycle after its grant.
- Halt: halted=1 with if_req=1 and no dm_req -> no grants and mem_en=0. Deassert halted -> if_gnt the same cycle.
- Reset mid-read: grant a load, pull rst_n low before the next edge -> dm_rvalid stays 0 through and after reset release.

Source files
------------

// File: rtl/mips32_mem_arbiter_if.sv
// mips32_mem_arbiter_if: fetch, data and memory port bundle of the unified memory arbiter
interface mips32_mem_arbiter_if #(parameter int ADDR_W = 10, parameter int DATA_W = 32);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mips32_mem_arbiter.sv
// mips32_mem_arbiter: shares one memory port between fetch and load/store, data first with a fetch starvation guard
module mips32_mem_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk1,
  input  logic                rst_n,
  input  logic                halted,
  mips32_mem_arbiter_if.slave bus,
  output logic [15:0]         conflict_cnt
);
  typedef enum logic [1:0] {NONE, IFO, DMO} owner_t;
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
  owner_t      owner_q, owner_d;
  logic [3:0]  starve_q, starve_d;
  logic [15:0] conflict_q, conflict_d;
  logic        ifr, boost, if_g, dm_g;
  always_ff @(posedge clk1 or negedge rst_n)
    if (!rst_n) begin
      owner_q    <= NONE;
      starve_q   <= '0;
      conflict_q <= '0;
    end else begin
      owner_q    <= owner_d;
      starve_q   <= starve_d;
      conflict_q <= conflict_d;
    end
  // grants are gated by rst_n so nothing reaches memory while reset is held
  always_comb begin
    ifr        = bus.if_req & ~halted;
    boost      = starve_q == LIM;
    if_g       = rst_n & ifr & (boost | ~bus.dm_req);
    dm_g       = rst_n & bus.dm_req & ~if_g;
    starve_d   = (if_g | ~ifr) ? 4'd0 : boost ? starve_q : starve_q + 4'd1;
    owner_d    = if_g ? IFO : (dm_g & ~bus.dm_we) ? DMO : NONE;
    conflict_d = (bus.dm_req & ifr & ~&conflict_q) ? conflict_q + 16'd1 : conflict_q;
  end
  always_comb begin
    bus.if_gnt    = if_g;
    bus.dm_gnt    = dm_g;
    bus.mem_en    = if_g | dm_g;
    bus.mem_we    = dm_g & bus.dm_we;
    bus.mem_addr  = if_g ? bus.if_addr : dm_g ? bus.dm_addr : {ADDR_W{1'b0}};
    bus.mem_wdata = dm_g ? bus.dm_wdata : {DATA_W{1'b0}};
    bus.if_rvalid = owner_q == IFO;
    bus.dm_rvalid = owner_q == DMO;
    bus.if_rdata  = (owner_q == IFO) ? bus.mem_rdata : {DATA_W{1'b0}};
    bus.dm_rdata  = (owner_q == DMO) ? bus.mem_rdata : {DATA_W{1'b0}};
  end
  assign conflict_cnt = conflict_q;
endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// tb_mips32_mem_arbiter: vector table plus directed sequences for starvation, halt and reset corner cases
module tb_mips32_mem_arbiter;
  logic        clk1 = 1'b0;
  logic        rst_n;
  logic        halted;
  logic [15:0] conflict_cnt;
  int          checks = 0;
  int          errors = 0;
  mips32_mem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus ();
  mips32_mem_arbiter #(.ADDR_W(10), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk1(clk1), .rst_n(rst_n), .halted(halted), .bus(bus), .conflict_cnt(conflict_cnt)
  );
  always #5 clk1 = ~clk1;
  // memory reads back k+100 at any address never written, one cycle after the strobe
  bit [31:0] mem [1024];
  bit        wr  [1024];
  always @(posedge clk1) begin
    if (bus.mem_en & bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
      wr[bus.mem_addr]  <= 1'b1;
    end
    if (bus.mem_en & ~bus.mem_we)
      bus.mem_rdata <= wr[bus.mem_addr] ? mem[bus.mem_addr] : 32'(bus.mem_addr) + 32'd100;
  end
  typedef struct {
    logic halted, if_req; logic [9:0] if_addr;
    logic dm_req, dm_we; logic [9:0] dm_addr; logic [31:0] dm_wdata;
    logic if_gnt, dm_gnt, mem_en, mem_we; logic [9:0] mem_addr; logic [31:0] mem_wdata;
    logic if_rvalid; logic [31:0] if_rdata; logic dm_rvalid; logic [31:0] dm_rdata;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t mk(
    logic h, logic ir, logic [9:0] ia, logic dr, logic dw, logic [9:0] da, logic [31:0] dd,
    logic ig, logic dg, logic me, logic mw, logic [9:0] ma, logic [31:0] md,
    logic iv, logic [31:0] id, logic dv, logic [31:0] dq);
    vec_t v;
    v.halted = h; v.if_req = ir; v.if_addr = ia; v.dm_req = dr; v.dm_we = dw; v.dm_addr = da;
    v.dm_wdata = dd; v.if_gnt = ig; v.dm_gnt = dg; v.mem_en = me; v.mem_we = mw;
    v.mem_addr = ma; v.mem_wdata = md; v.if_rvalid = iv; v.if_rdata = id;
    v.dm_rvalid = dv; v.dm_rdata = dq;
    return v;
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", n, a, e);
    end
  endtask
  task automatic drive(input logic h, input logic ir, input logic [9:0] ia,
                       input logic dr, input logic dw, input logic [9:0] da, input logic [31:0] dd);
    halted = h; bus.if_req = ir; bus.if_addr = ia;
    bus.dm_req = dr; bus.dm_we = dw; bus.dm_addr = da; bus.dm_wdata = dd;
  endtask
  task automatic do_reset();
    @(negedge clk1);
    drive(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    @(negedge clk1);
    rst_n = 1'b1;
  endtask
  initial begin
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk(0, 1, 10'(k), 0, 0, 0, 0, 1, 0, 1, 0, 10'(k), 0,
                       k > 0, k > 0 ? 32'(99 + k) : 32'd0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0,     1, 107, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 120, 85, 0, 1, 1, 1, 120, 85,  0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 120, 0,  0, 1, 1, 0, 120, 0,   0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0,     0, 0, 1, 85));
    tbl.push_back(mk(1, 1, 7, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0,     0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3, 0, 0, 0, 0,    1, 0, 1, 0, 3, 0,     0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0,     1, 103, 0, 0));
    tbl.push_back(mk(0, 1, 6, 1, 0, 4, 0,    0, 1, 1, 0, 4, 0,     0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0,     0, 0, 1, 104));
    tbl.push_back(mk(1, 1, 2, 1, 0, 5, 0,    0, 1, 1, 0, 5, 0,     0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0,     0, 0, 1, 105));
    rst_n = 1'b0;
    drive(0, 1, 1, 1, 0, 2, 0);
    repeat (2) @(negedge clk1);
    #1;
    chk("rst_if_gnt", 32'(bus.if_gnt), 0);
    chk("rst_dm_gnt", 32'(bus.dm_gnt), 0);
    chk("rst_mem_en", 32'(bus.mem_en), 0);
    chk("rst_rvalid", {30'd0, bus.if_rvalid, bus.dm_rvalid}, 0);
    chk("rst_rdata", bus.if_rdata | bus.dm_rdata, 0);
    chk("rst_conflict", 32'(conflict_cnt), 0);
    @(negedge clk1);
    rst_n = 1'b1;
    #1;
    chk("rel_dm_gnt", 32'(bus.dm_gnt), 1);
    chk("rel_if_gnt", 32'(bus.if_gnt), 0);
    do_reset();
    foreach (tbl[r]) begin
      @(negedge clk1);
      drive(tbl[r].halted, tbl[r].if_req, tbl[r].if_addr, tbl[r].dm_req,
            tbl[r].dm_we, tbl[r].dm_addr, tbl[r].dm_wdata);
      #1;
      chk($sformatf("v%0d_if_gnt", r), 32'(bus.if_gnt), 32'(tbl[r].if_gnt));
      chk($sformatf("v%0d_dm_gnt", r), 32'(bus.dm_gnt), 32'(tbl[r].dm_gnt));
      chk($sformatf("v%0d_mem_en", r), 32'(bus.mem_en), 32'(tbl[r].mem_en));
      chk($sformatf("v%0d_mem_we", r), 32'(bus.mem_we), 32'(tbl[r].mem_we));
      chk($sformatf("v%0d_mem_addr", r), 32'(bus.mem_addr), 32'(tbl[r].mem_addr));
      chk($sformatf("v%0d_mem_wdata", r), bus.mem_wdata, tbl[r].mem_wdata);
      chk($sformatf("v%0d_if_rvalid", r), 32'(bus.if_rvalid), 32'(tbl[r].if_rvalid));
      chk($sformatf("v%0d_if_rdata", r), bus.if_rdata, tbl[r].if_rdata);
      chk($sformatf("v%0d_dm_rvalid", r), 32'(bus.dm_rvalid), 32'(tbl[r].dm_rvalid));
      chk($sformatf("v%0d_dm_rdata", r), bus.dm_rdata, tbl[r].dm_rdata);
    end
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk1);
      drive(0, 1, 1, 1, 0, 2, 0);
      #1;
      chk($sformatf("starve%0d_if_gnt", i), 32'(bus.if_gnt), 32'(i == 4 || i == 9));
      chk($sformatf("starve%0d_dm_gnt", i), 32'(bus.dm_gnt), 32'(!(i == 4 || i == 9)));
    end
    @(negedge clk1);
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("starve_conflict", 32'(conflict_cnt), 10);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk1);
      drive(i == 3, 1, 1, 1, 0, 2, 0);
      #1;
      chk($sformatf("halt%0d_dm_gnt", i), 32'(bus.dm_gnt), 1);
      chk($sformatf("halt%0d_if_gnt", i), 32'(bus.if_gnt), 0);
    end
    @(negedge clk1);
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("halt_conflict", 32'(conflict_cnt), 4);
    do_reset();
    @(negedge clk1);
    drive(0, 0, 0, 1, 0, 120, 0);
    #1;
    chk("midrd_dm_gnt", 32'(bus.dm_gnt), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrd_gnt_forced", 32'(bus.dm_gnt), 0);
    @(negedge clk1);
    chk("midrd_rvalid_in_rst", 32'(bus.dm_rvalid), 0);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("midrd_rvalid_rel", 32'(bus.dm_rvalid), 0);
    @(negedge clk1);
    #1;
    chk("midrd_rvalid_after", 32'(bus.dm_rvalid), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
